// File: rtl/rgbled_rx.sv
// rgbled_rx: WS2812-style single-wire receiver.
// Measures each high pulse on a synchronized copy of data_i, turns it into
// one bit, assembles 24-bit words (first bit into rgb_o[23]) and offers them
// on a valid/ready output register.
//
// Output handshake: rgb_o carries a word whenever valid_o is 1. A word is
// taken by the consumer on a rising clk_i edge where valid_o && ready_i.
// While valid_o && !ready_i, rgb_o and valid_o hold. A word that completes
// while the register is still full and not being taken is dropped and
// reported on overflow_o.
//
// Debug: state_o shows the decoder state (0 RESYNC, 1 IDLE, 2 HIGH, 3 LOW).
`timescale 1ns/1ps

module rgbled_rx #(
    parameter int SysClkFreq    = 40_000_000,
    parameter int ThreshCycles  = SysClkFreq * 3 / 5_000_000,
    parameter int MinHighCycles = SysClkFreq * 3 / 20_000_000,
    parameter int MaxHighCycles = SysClkFreq * 3 / 2_000_000,
    parameter int ResetCycles   = SysClkFreq / 20_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_i,
    output logic [23:0] rgb_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        frame_end_o,
    output logic        err_o,
    output logic        overflow_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_RESYNC = 2'd0,
        ST_IDLE   = 2'd1,
        ST_HIGH   = 2'd2,
        ST_LOW    = 2'd3
    } state_t;

    localparam logic [15:0] THRESH_C = 16'(ThreshCycles);
    localparam logic [15:0] MIN_C    = 16'(MinHighCycles);
    localparam logic [15:0] MAX_C    = 16'(MaxHighCycles);
    localparam logic [15:0] RESET_C  = 16'(ResetCycles);

    logic [1:0]  sync_q;
    logic        line_s;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [22:0] shift_q, shift_d;
    logic [23:0] word_d;
    logic        word_done;
    logic        bit_in;
    logic        err_d;
    logic        frame_end_d;

    assign line_s  = sync_q[1];
    assign state_o = state_q;
    // The counter saturates so an endless low never wraps into a false timing.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign bit_in  = (cnt_q >= THRESH_C);

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], data_i};
        end
    end

    // Decoder state, counters and shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RESYNC;
            cnt_q     <= 16'd0;
            bit_cnt_q <= 5'd0;
            shift_q   <= 23'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state decode: pulse timing, bit extraction and error detection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        word_d      = {shift_q, bit_in};
        word_done   = 1'b0;
        err_d       = 1'b0;
        frame_end_d = 1'b0;
        case (state_q)
            ST_RESYNC: begin
                // Wait for a full reset gap before trusting the line again.
                if (line_s) begin
                    cnt_d = 16'd0;
                end else if (cnt_q >= RESET_C) begin
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_IDLE: begin
                if (line_s) begin
                    cnt_d   = 16'd1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt_q >= MAX_C) begin
                    // Stuck-high line: abandon the word.
                    err_d     = 1'b1;
                    bit_cnt_d = 5'd0;
                    cnt_d     = 16'd0;
                    state_d   = ST_RESYNC;
                end else if (line_s) begin
                    cnt_d = cnt_inc;
                end else if (cnt_q < MIN_C) begin
                    // Glitch-length pulse: abandon the word.
                    err_d     = 1'b1;
                    bit_cnt_d = 5'd0;
                    cnt_d     = 16'd0;
                    state_d   = ST_RESYNC;
                end else begin
                    shift_d = {shift_q[21:0], bit_in};
                    if (bit_cnt_q == 5'd23) begin
                        word_done = 1'b1;
                        bit_cnt_d = 5'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                    cnt_d   = 16'd1;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (line_s) begin
                    cnt_d   = 16'd1;
                    state_d = ST_HIGH;
                end else if (cnt_q >= RESET_C) begin
                    // Reset gap ends the frame; a partial word is an error.
                    frame_end_d = 1'b1;
                    err_d       = (bit_cnt_q != 5'd0);
                    bit_cnt_d   = 5'd0;
                    cnt_d       = 16'd0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d     = 16'd0;
                bit_cnt_d = 5'd0;
                state_d   = ST_RESYNC;
            end
        endcase
    end

    // Output word register with valid/ready hold and overflow reporting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_o       <= 24'd0;
            valid_o     <= 1'b0;
            overflow_o  <= 1'b0;
            err_o       <= 1'b0;
            frame_end_o <= 1'b0;
        end else begin
            err_o       <= err_d;
            frame_end_o <= frame_end_d;
            overflow_o  <= 1'b0;
            if (word_done && (!valid_o || ready_i)) begin
                rgb_o   <= word_d;
                valid_o <= 1'b1;
            end else begin
                if (word_done) begin
                    overflow_o <= 1'b1;
                end
                if (valid_o && ready_i) begin
                    valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgbled_rx.sv
// tb_rgbled_rx: self-checking bench for rgbled_rx at 40 MHz defaults.
// Bits: 0 = 16 high / 34 low cycles, 1 = 32 high / 18 low cycles.
`timescale 1ns/1ps

module tb_rgbled_rx;

    localparam logic [1:0] ST_RESYNC = 2'd0;

    logic        clk;
    logic        rst_n;
    logic        data_i;
    logic        ready_i;
    logic [23:0] rgb_o;
    logic        valid_o;
    logic        frame_end_o;
    logic        err_o;
    logic        overflow_o;
    logic [1:0]  state_o;

    logic [23:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fe_cnt   = 0;
    int err_cnt  = 0;
    int ovf_cnt  = 0;
    int both_cnt = 0;
    int last_fall_cyc  = 0;
    int valid_rise_cyc = 0;
    logic acc_prev   = 1'b0;
    logic valid_prev = 1'b0;

    rgbled_rx dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .data_i      (data_i),
        .rgb_o       (rgb_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_end_o (frame_end_o),
        .err_o       (err_o),
        .overflow_o  (overflow_o),
        .state_o     (state_o)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        data_i = 1'b1;
        tick(b ? 32 : 16);
        data_i = 1'b0;
        last_fall_cyc = cyc;
        tick(b ? 18 : 34);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 23; i >= 24 - n; i--) send_bit(w[i]);
    endtask

    task automatic gap(input int n);
        data_i = 1'b0;
        tick(n);
    endtask

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_prev) check("valid_clear", {31'd0, valid_o}, 32'd0);
            acc_prev = valid_o && ready_i;
            if (valid_o && !valid_prev) valid_rise_cyc = cyc;
            valid_prev = valid_o;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) check("spurious_valid", {31'd0, valid_o}, 32'd0);
                else check("word", {8'd0, rgb_o}, {8'd0, exp_q.pop_front()});
            end
            if (frame_end_o) fe_cnt++;
            if (err_o) err_cnt++;
            if (overflow_o) ovf_cnt++;
            if (frame_end_o && err_o) both_cnt++;
        end else begin
            acc_prev   = 1'b0;
            valid_prev = 1'b0;
        end
    end

    initial begin
        int fe0, err0, ovf0, both0;
        rst_n   = 1'b0;
        data_i  = 1'b0;
        ready_i = 1'b1;
        #2;
        check("rst_rgb", {8'd0, rgb_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_pulses", {29'd0, frame_end_o, err_o, overflow_o}, 32'd0);
        check("rst_state", {30'd0, state_o}, {30'd0, ST_RESYNC});
        tick(3);
        rst_n = 1'b1;
        gap(2010);

        // basic word, latency and frame end
        fe0 = fe_cnt; err0 = err_cnt;
        exp_q.push_back(24'hFF0055);
        send_bits(24'hFF0055, 24);
        gap(2100);
        check("latency", valid_rise_cyc - last_fall_cyc, 32'd3);
        check("s1_frame_end", fe_cnt - fe0, 32'd1);
        check("s1_err", err_cnt - err0, 32'd0);
        check("s1_valid_low", {31'd0, valid_o}, 32'd0);

        // back-to-back with consumer stalled
        fe0 = fe_cnt; ovf0 = ovf_cnt;
        ready_i = 1'b0;
        exp_q.push_back(24'h123456);
        send_bits(24'h123456, 24);
        send_bits(24'hABCDEF, 24);
        gap(2100);
        check("s2_hold_rgb", {8'd0, rgb_o}, 32'h123456);
        check("s2_hold_valid", {31'd0, valid_o}, 32'd1);
        check("s2_overflow", ovf_cnt - ovf0, 32'd1);
        check("s2_frame_end", fe_cnt - fe0, 32'd1);
        ready_i = 1'b1;
        tick(3);
        check("s2_valid_cleared", {31'd0, valid_o}, 32'd0);

        // short pulse mid-word, junk word ignored until a full gap
        fe0 = fe_cnt; err0 = err_cnt;
        send_bits(24'hA50000, 5);
        data_i = 1'b1; tick(4);
        gap(30);
        send_bits(24'h0F0F0F, 24);
        gap(2100);
        check("s3_err", err_cnt - err0, 32'd1);
        check("s3_no_frame_end", fe_cnt - fe0, 32'd0);
        check("s3_no_valid", {31'd0, valid_o}, 32'd0);
        exp_q.push_back(24'h5AA5C3);
        send_bits(24'h5AA5C3, 24);
        gap(2100);
        check("s3_frame_end", fe_cnt - fe0, 32'd1);

        // stuck-high line
        fe0 = fe_cnt; err0 = err_cnt;
        data_i = 1'b1;
        tick(68);
        check("s4_err", err_cnt - err0, 32'd1);
        check("s4_state", {30'd0, state_o}, {30'd0, ST_RESYNC});
        tick(2);
        gap(2100);
        check("s4_err_once", err_cnt - err0, 32'd1);
        check("s4_no_frame_end", fe_cnt - fe0, 32'd0);

        // partial word ended by a reset gap
        fe0 = fe_cnt; err0 = err_cnt; both0 = both_cnt;
        send_bits(24'hFFC000, 10);
        gap(2100);
        check("s5_frame_end", fe_cnt - fe0, 32'd1);
        check("s5_err", err_cnt - err0, 32'd1);
        check("s5_same_cycle", both_cnt - both0, 32'd1);
        check("s5_no_valid", {31'd0, valid_o}, 32'd0);
        exp_q.push_back(24'h00FF00);
        send_bits(24'h00FF00, 24);
        gap(2100);

        // reset in the middle of a word with a held output word
        ready_i = 1'b0;
        send_bits(24'hC0FFEE, 24);
        gap(2100);
        check("s6_held", {8'd0, rgb_o}, 32'hC0FFEE);
        send_bits(24'h24680A, 12);
        rst_n = 1'b0;
        #1;
        check("s6_rst_rgb", {8'd0, rgb_o}, 32'd0);
        check("s6_rst_valid", {31'd0, valid_o}, 32'd0);
        check("s6_rst_pulses", {29'd0, frame_end_o, err_o, overflow_o}, 32'd0);
        check("s6_rst_state", {30'd0, state_o}, {30'd0, ST_RESYNC});
        tick(3);
        rst_n = 1'b1;
        ready_i = 1'b1;
        fe0 = fe_cnt; err0 = err_cnt;
        send_bits(24'h777777, 24);
        gap(2100);
        check("s6_ignored", {31'd0, valid_o}, 32'd0);
        check("s6_no_frame_end", fe_cnt - fe0, 32'd0);
        exp_q.push_back(24'h13579B);
        send_bits(24'h13579B, 24);
        gap(2100);
        check("s6_err", err_cnt - err0, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgbled_rx.md
RGBLED_RX -- requirements
Module: rgbled_rx

Interface
REQ-001 The parameter SysClkFreq SHALL default to 40_000_000 and give the clk_i frequency in Hz.
REQ-002 The parameter ThreshCycles SHALL default to SysClkFreq*3/5_000_000 (24): the minimum high time, in cycles, that decodes as 1.
REQ-003 The parameter MinHighCycles SHALL default to SysClkFreq*3/20_000_000 (6): high pulses shorter than this are errors.
REQ-004 The parameter MaxHighCycles SHALL default to SysClkFreq*3/2_000_000 (60): a high pulse reaching this length is an error.
REQ-005 The parameter ResetCycles SHALL default to SysClkFreq/20_000 (2000): the low time that ends a frame; it shall be below 65536.
REQ-006 Port clk_i SHALL be an input, 1 bit wide: the system clock.
REQ-007 Port rst_ni SHALL be an input, 1 bit wide: an asynchronous, active-low reset.
REQ-008 Port data_i SHALL be an input, 1 bit wide: the WS2812-style serial line, asynchronous to clk_i.
REQ-009 Port rgb_o SHALL be an output, 24 bits wide: the decoded word, with the first received bit in rgb_o[23] (wire order G,R,B).
REQ-010 Port valid_o SHALL be an output, 1 bit wide: rgb_o holds a word.
REQ-011 Port ready_i SHALL be an input, 1 bit wide: the consumer accepts rgb_o.
REQ-012 Port frame_end_o SHALL be an output, 1 bit wide: a one-cycle pulse when a reset gap is detected.
REQ-013 Port err_o SHALL be an output, 1 bit wide: a one-cycle pulse on a protocol error.
REQ-014 Port overflow_o SHALL be an output, 1 bit wide: a one-cycle pulse when a completed word is dropped.

Function
REQ-015 data_i SHALL pass through a 2-flop synchronizer; all decoding SHALL use only the synchronized line (line_s).
REQ-016 The FSM SHALL have the states RESYNC, IDLE, HIGH and LOW, with a 16-bit saturating cycle counter cnt and a 5-bit bit counter bit_cnt.
REQ-017 In RESYNC, cnt SHALL count cycles with line_s=0 and clear to 0 on line_s=1; when cnt reaches ResetCycles the FSM SHALL go to IDLE with no frame_end_o.
REQ-018 In IDLE, a line_s rising edge SHALL move the FSM to HIGH with cnt=1.
REQ-019 In HIGH, cnt SHALL increment each cycle while line_s=1.
REQ-020 In HIGH, if cnt reaches MaxHighCycles, the block SHALL pulse err_o, discard the partial word (bit_cnt=0) and go to RESYNC.
REQ-021 On a falling edge in HIGH, cnt<MinHighCycles SHALL pulse err_o, set bit_cnt=0 and go to RESYNC.
REQ-022 On any other falling edge in HIGH, the block SHALL shift in bit (cnt>=ThreshCycles), increment bit_cnt, set cnt=1 and go to LOW.
REQ-023 In LOW, a rising edge SHALL go to HIGH with cnt=1; the low time SHALL NOT be checked against a minimum.
REQ-024 In LOW, when cnt reaches ResetCycles: frame_end_o SHALL pulse; if bit_cnt!=0, err_o SHALL pulse in the same cycle and the partial word SHALL be discarded; bit_cnt=0; the FSM SHALL go to IDLE.
REQ-025 When bit_cnt reaches 24, the word SHALL complete and bit_cnt SHALL wrap to 0.
REQ-026 On completion with valid_o=0 (or valid_o=1 and ready_i=1 in the same cycle), rgb_o SHALL load and valid_o SHALL be 1 in the next cycle; latency from the 24th data_i falling edge to valid_o is 3 cycles.
REQ-027 On completion with valid_o=1 and ready_i=0, overflow_o SHALL pulse, the new word SHALL be dropped, and rgb_o/valid_o SHALL remain unchanged.
REQ-028 valid_o SHALL clear on the cycle after valid_o&&ready_i unless a new word loads that cycle; rgb_o SHALL be stable while valid_o&&!ready_i.
REQ-029 Errors and frame ends SHALL NOT affect a word already held in rgb_o.

Reset
REQ-030 With rst_ni=0, the state SHALL be RESYNC, cnt and bit_cnt 0, the synchronizer 0, rgb_o 0, and valid_o, frame_end_o, err_o and overflow_o 0, independent of clk_i.
REQ-031 A reset mid-word SHALL discard all partial data; after release, decoding SHALL resume only after a full ResetCycles low gap.

Verification (40 MHz defaults; 0=16 high/34 low cycles, 1=32 high/18 low)
REQ-032 Scenario: after reset, drive low for 2000 cycles, then send 0xFF0055 followed by a low of 2000+ cycles with ready_i=1. Required: rgb_o=0xFF0055 and valid_o for 1 cycle, 3 cycles after the 24th fall; frame_end_o pulses once.
REQ-033 Scenario: send 0x123456 then 0xABCDEF back-to-back with ready_i=0. Required: rgb_o stays 0x123456, overflow_o pulses once; after raising ready_i, valid_o clears.
REQ-034 Scenario: a 4-cycle high pulse mid-word. Required: err_o pulses, no word is output; the next word decodes only after a 2000-cycle low gap.
REQ-035 Scenario: hold the line high for 70 cycles. Required: err_o pulses when cnt=60, and the block is in RESYNC.
REQ-036 Scenario: send 10 bits then a 2000-cycle low. Required: frame_end_o and err_o pulse in the same cycle, valid_o stays 0.
REQ-037 Scenario: assert rst_ni=0 after bit 12 of a word, then release. Required: all outputs are 0 immediately, and the first word after a 2000-cycle gap decodes correctly.
